// File: rtl/bus_console_bridge.sv
// Byte-stream bridge between the core's UARC send/receive buses and one host
// tx/rx byte port. Each channel has an outbound FIFO with a programmable
// send-ack delay and an inbound show-ahead FIFO. Outbound bytes from all
// channels share the tx port through a round-robin arbiter.
module bus_console_bridge #(
  parameter int WORD_WIDTH = 32,
  parameter int CHANNELS   = 1,
  parameter int FIFO_MAG   = 4,
  parameter int ACK_DELAY  = 4,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            bus_sends,
  input  logic [WORD_WIDTH-1:0]          bus_data,
  output logic [CHANNELS-1:0]            bus_send_acks,
  output logic [CHANNELS-1:0]            bus_recv_sends,
  output logic [CHANNELS*WORD_WIDTH-1:0] bus_recv_datas,
  input  logic [CHANNELS-1:0]            bus_recv_acks,
  output logic                           tx_valid,
  output logic [CH_W-1:0]                tx_channel,
  output logic [7:0]                     tx_data,
  input  logic                           tx_ready,
  input  logic                           rx_valid,
  input  logic [CH_W-1:0]                rx_channel,
  input  logic [7:0]                     rx_data,
  output logic                           rx_ready
);

  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_DELAY - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]          tx_state;
  logic [CH_W-1:0]     grant;
  logic [CH_W-1:0]     last_grant;
  logic [CH_W-1:0]     next_grant;
  logic [CH_W-1:0]     pick_hi;
  logic [CH_W-1:0]     pick_lo;
  logic                found_hi;
  logic                any_pending;
  logic                tx_fire;
  logic [7:0]          head_sel;
  logic                rx_hit;
  logic                rx_full_sel;
  logic [CHANNELS-1:0] ch_out_nonempty;
  logic [CHANNELS-1:0] ch_in_full;
  logic [7:0]          out_head [CHANNELS];

  // Only the low byte of a send word is carried; the rest is dropped on purpose.
  logic data_hi_unused;
  assign data_hi_unused = ^bus_data[WORD_WIDTH-1:8];

  assign tx_fire = (tx_state == ST_OFFER) && tx_ready;

  // Round-robin pick: lowest pending channel above last_grant, else lowest overall.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_hi     = '0;
    pick_lo     = '0;
    found_hi    = 1'b0;
    any_pending = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (ch_out_nonempty[c]) begin
        pick_lo     = CH_W'(c);
        any_pending = 1'b1;
        if (CH_W'(c) > last_grant) begin
          pick_hi  = CH_W'(c);
          found_hi = 1'b1;
        end
      end
    end
    next_grant = found_hi ? pick_hi : pick_lo;
  end

  // Tx arbiter: latch a grant in IDLE, hold the offer until the host takes it.
  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state   <= ST_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(CHANNELS - 1);
    end else if (tx_state == ST_IDLE) begin
      if (any_pending) begin
        grant    <= next_grant;
        tx_state <= ST_OFFER;
      end
    end else if (tx_ready) begin
      last_grant <= grant;
      tx_state   <= ST_IDLE;
    end
  end

  // Head byte of the granted outbound FIFO.
  always_comb begin
    head_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant == CH_W'(c)) head_sel = out_head[c];
    end
  end

  assign tx_valid   = (tx_state == ST_OFFER);
  assign tx_channel = tx_valid ? grant : '0;
  assign tx_data    = tx_valid ? head_sel : '0;

  // Inbound accept: addressed channel must exist and have room.
  always_comb begin
    rx_hit      = 1'b0;
    rx_full_sel = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rx_channel == CH_W'(c)) begin
        rx_hit      = 1'b1;
        rx_full_sel = ch_in_full[c];
      end
    end
  end

  assign rx_ready = reset && rx_valid && rx_hit && !rx_full_sel;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]        out_mem [1 << FIFO_MAG];
    logic [7:0]        in_mem  [1 << FIFO_MAG];
    logic [FIFO_MAG:0] out_wp, out_rp, in_wp, in_rp;
    logic [CNT_W-1:0]  cnt;
    logic              ack_q;
    logic              out_full, out_empty, out_push, out_pop;
    logic              in_full, in_empty, in_push, in_pop;

    assign out_empty = (out_wp == out_rp);
    assign out_full  = (out_wp[FIFO_MAG] != out_rp[FIFO_MAG]) &&
                       (out_wp[FIFO_MAG-1:0] == out_rp[FIFO_MAG-1:0]);
    assign in_empty  = (in_wp == in_rp);
    assign in_full   = (in_wp[FIFO_MAG] != in_rp[FIFO_MAG]) &&
                       (in_wp[FIFO_MAG-1:0] == in_rp[FIFO_MAG-1:0]);

    assign out_push = bus_sends[c] && !out_full && (cnt == CNT_LAST);
    assign out_pop  = tx_fire && (grant == CH_W'(c));
    assign in_push  = rx_ready && (rx_channel == CH_W'(c));
    assign in_pop   = bus_recv_acks[c] && !in_empty;

    // Send handshake: count held-send cycles; ack and push on the last one.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        ack_q <= 1'b0;
      end else if (!bus_sends[c]) begin
        cnt   <= '0;
        ack_q <= 1'b0;
      end else if (out_full) begin
        ack_q <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        ack_q <= 1'b1;
      end else begin
        cnt   <= cnt + 1'b1;
        ack_q <= 1'b0;
      end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_wp <= '0;
        out_rp <= '0;
        in_wp  <= '0;
        in_rp  <= '0;
      end else begin
        if (out_push) out_wp <= out_wp + 1'b1;
        if (out_pop)  out_rp <= out_rp + 1'b1;
        if (in_push)  in_wp  <= in_wp + 1'b1;
        if (in_pop)   in_rp  <= in_rp + 1'b1;
      end
    end

    // Byte storage for both directions.
    // NOTE: storage arrays carry no reset; emptiness comes from the pointers, so stale bytes are never visible.
    always_ff @(posedge clk) begin
      if (out_push) out_mem[out_wp[FIFO_MAG-1:0]] <= bus_data[7:0];
      if (in_push)  in_mem[in_wp[FIFO_MAG-1:0]]   <= rx_data;
    end

    assign bus_send_acks[c]   = ack_q;
    assign ch_out_nonempty[c] = !out_empty;
    assign ch_in_full[c]      = in_full;
    assign out_head[c]        = out_mem[out_rp[FIFO_MAG-1:0]];
    assign bus_recv_sends[c]  = !in_empty;
    assign bus_recv_datas[c*WORD_WIDTH +: WORD_WIDTH] =
      in_empty ? '0 : WORD_WIDTH'(in_mem[in_rp[FIFO_MAG-1:0]]);
  end

endmodule

// File: tb/tb_bus_console_bridge.sv
// Self-checking bench for bus_console_bridge (3 channels, ack delay 4, depth 16).
// A queue-based model predicts every output each cycle; directed literal
// checks pin the scenarios that matter.
module tb_bus_console_bridge;

  localparam int W     = 32;
  localparam int CH    = 3;
  localparam int CW    = 2;
  localparam int AD    = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   bus_sends;
  logic [W-1:0]    bus_data;
  logic [CH-1:0]   bus_send_acks;
  logic [CH-1:0]   bus_recv_sends;
  logic [CH*W-1:0] bus_recv_datas;
  logic [CH-1:0]   bus_recv_acks;
  logic            tx_valid;
  logic [CW-1:0]   tx_channel;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic            rx_valid;
  logic [CW-1:0]   rx_channel;
  logic [7:0]      rx_data;
  logic            rx_ready;

  always #5 clk = ~clk;

  bus_console_bridge #(
    .WORD_WIDTH(W), .CHANNELS(CH), .FIFO_MAG(4), .ACK_DELAY(AD)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_sends(bus_sends), .bus_data(bus_data), .bus_send_acks(bus_send_acks),
    .bus_recv_sends(bus_recv_sends), .bus_recv_datas(bus_recv_datas),
    .bus_recv_acks(bus_recv_acks),
    .tx_valid(tx_valid), .tx_channel(tx_channel), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_channel(rx_channel), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_out [CH][$];
  logic [7:0] m_in  [CH][$];
  int         m_held [CH];
  bit         m_ack  [CH];
  bit         m_offer = 1'b0;
  int         m_grant = 0;
  int         m_last  = CH - 1;
  bit         pre_full [CH];
  bit         pre_ne   [CH];
  bit         pre_rx;
  int         pick;

  function automatic bit model_rx_ready();
    if (reset !== 1'b1 || rx_valid !== 1'b1 || int'(rx_channel) >= CH) return 1'b0;
    return m_in[rx_channel].size() < DEPTH;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        m_out[c].delete();
        m_in[c].delete();
        m_held[c] = 0;
        m_ack[c]  = 1'b0;
      end
      m_offer = 1'b0;
      m_grant = 0;
      m_last  = CH - 1;
    end else begin
      pre_rx = model_rx_ready();
      for (int c = 0; c < CH; c++) begin
        pre_full[c] = (m_out[c].size() == DEPTH);
        pre_ne[c]   = (m_in[c].size() != 0);
      end
      if (m_offer) begin
        if (tx_ready) begin
          void'(m_out[m_grant].pop_front());
          m_last  = m_grant;
          m_offer = 1'b0;
        end
      end else begin
        pick = -1;
        for (int k = 1; k <= CH; k++)
          if (pick < 0 && m_out[(m_last + k) % CH].size() != 0) pick = (m_last + k) % CH;
        if (pick >= 0) begin
          m_grant = pick;
          m_offer = 1'b1;
        end
      end
      for (int c = 0; c < CH; c++) begin
        m_ack[c] = 1'b0;
        if (!bus_sends[c]) m_held[c] = 0;
        else if (!pre_full[c]) begin
          m_held[c]++;
          if (m_held[c] == AD) begin
            m_held[c] = 0;
            m_ack[c]  = 1'b1;
            m_out[c].push_back(bus_data[7:0]);
          end
        end
      end
      for (int c = 0; c < CH; c++)
        if (bus_recv_acks[c] && pre_ne[c]) void'(m_in[c].pop_front());
      if (pre_rx) m_in[rx_channel].push_back(rx_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [CH-1:0] e_ack, e_rs;
  logic [W-1:0]  e_dat;
  logic [CW-1:0] e_tc;
  logic [7:0]    e_td;
  int            hs_count  = 0;
  int            ack_count = 0;
  logic [7:0]    last_tx_data = 8'h00;
  int            tx_log [$];

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      e_ack[c] = m_ack[c];
      e_rs[c]  = (m_in[c].size() != 0);
    end
    check("cmp_send_acks", bus_send_acks, e_ack);
    check("cmp_recv_sends", bus_recv_sends, e_rs);
    for (int c = 0; c < CH; c++) begin
      e_dat = e_rs[c] ? {24'h0, m_in[c][0]} : '0;
      check("cmp_recv_data", bus_recv_datas[c*W +: W], e_dat);
    end
    e_tc = m_offer ? CW'(m_grant) : '0;
    e_td = m_offer ? m_out[m_grant][0] : 8'h00;
    check("cmp_tx_valid", tx_valid, m_offer);
    check("cmp_tx_channel", tx_channel, e_tc);
    check("cmp_tx_data", tx_data, e_td);
    check("cmp_rx_ready", rx_ready, model_rx_ready());
    if (tx_valid && tx_ready) begin
      hs_count++;
      last_tx_data = tx_data;
      tx_log.push_back(int'(tx_channel));
    end
    if (bus_send_acks[0]) ack_count++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int hs0, a0;
  int exp_rr [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    reset = 1'b0; bus_sends = '0; bus_data = '0; bus_recv_acks = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_channel = '0; rx_data = '0;
    cyc(3);
    check("rst_send_acks", bus_send_acks, 0);
    check("rst_recv_sends", bus_recv_sends, 0);
    check("rst_recv_datas", bus_recv_datas[63:0], 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 0);
    reset = 1'b1;
    cyc(2);

    // Single send: ack one cycle after the 4th edge, byte offered on tx.
    bus_data = 32'h0000_0148; bus_sends = 3'b001; tx_ready = 1'b1;
    cyc(3); check("t1_no_early_ack", bus_send_acks[0], 0);
    cyc(1); check("t1_ack_after_4", bus_send_acks[0], 1);
    bus_sends = '0;
    cyc(1);
    check("t1_ack_one_cycle", bus_send_acks[0], 0);
    check("t1_tx_valid", tx_valid, 1);
    check("t1_tx_data", tx_data, 8'h48);
    check("t1_tx_channel", tx_channel, 0);
    cyc(2);

    // Abandoned send restarts the count; exactly one byte results.
    hs0 = hs_count;
    bus_data = 32'hABCD_0055; bus_sends = 3'b001;
    cyc(2); bus_sends = '0;
    cyc(1); bus_sends = 3'b001;
    cyc(3); check("t2_no_ack_after_3", bus_send_acks[0], 0);
    cyc(1); check("t2_ack_after_4", bus_send_acks[0], 1);
    bus_sends = '0;
    cyc(4);
    check("t2_one_byte", hs_count - hs0, 1);
    check("t2_byte_value", last_tx_data, 8'h55);

    // Outbound FIFO fills with tx blocked: 16 acks then a stall.
    tx_ready = 1'b0; a0 = ack_count; bus_sends = 3'b001;
    for (int k = 0; k < 16 * AD + 8; k++) begin
      bus_data = 32'h100 | (k / AD);
      cyc(1);
    end
    check("t3_sixteen_acks", ack_count - a0, 16);
    check("t3_offer_valid", tx_valid, 1);
    check("t3_offer_head", tx_data, 8'h00);
    hs0 = hs_count;
    bus_data = 32'h0000_01A5; tx_ready = 1'b1;
    cyc(1); tx_ready = 1'b0;
    cyc(3); check("t3_no_ack_yet", bus_send_acks[0], 0);
    cyc(1); check("t3_17th_ack", bus_send_acks[0], 1);
    bus_sends = '0; tx_ready = 1'b1;
    cyc(40);
    check("t3_drained", hs_count - hs0, 17);
    check("t3_last_byte", last_tx_data, 8'hA5);

    // Inbound bytes to the core, show-ahead with acks.
    rx_valid = 1'b1; rx_channel = 2'd0; rx_data = 8'h48;
    #1 check("t4_rx_ready", rx_ready, 1);
    cyc(1); rx_data = 8'h49;
    cyc(1); rx_data = 8'h0D;
    cyc(1); rx_valid = 1'b0;
    check("t4_sends_h48", bus_recv_sends[0], 1);
    check("t4_data_h48", bus_recv_datas[31:0], 32'h0000_0048);
    bus_recv_acks = 3'b001; cyc(1); bus_recv_acks = '0;
    check("t4_data_h49", bus_recv_datas[31:0], 32'h0000_0049);
    bus_recv_acks = 3'b001; cyc(1); bus_recv_acks = '0;
    check("t4_data_h0d", bus_recv_datas[31:0], 32'h0000_000D);
    bus_recv_acks = 3'b001; cyc(1); bus_recv_acks = '0;
    check("t4_sends_empty", bus_recv_sends[0], 0);
    for (int k = 0; k < DEPTH; k++) begin
      rx_valid = 1'b1; rx_data = 8'h60 + 8'(k);
      cyc(1);
    end
    rx_data = 8'hEE;
    #1 check("t4_full_17th", rx_ready, 0);
    check("t4_full_head", bus_recv_datas[31:0], 32'h0000_0060);
    bus_recv_acks = 3'b001;
    #1 check("t4_full_pop_no_push", rx_ready, 0);
    rx_valid = 1'b0;
    cyc(2);
    rx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rx_data = 8'h70 + 8'(k);
      cyc(1);
    end
    bus_recv_acks = '0; rx_channel = 2'd3;
    #1 check("t4_bad_channel", rx_ready, 0);
    cyc(1);
    rx_channel = 2'd2; rx_data = 8'h33;
    cyc(1); rx_valid = 1'b0; rx_channel = 2'd0;
    check("t4_ch2_sends", bus_recv_sends[2], 1);
    check("t4_ch2_data", bus_recv_datas[95:64], 32'h0000_0033);
    bus_recv_acks = 3'b111;
    cyc(20); bus_recv_acks = '0;
    check("t4_all_drained", bus_recv_sends, 0);

    // Round robin over three preloaded channels.
    reset = 1'b0; cyc(2); reset = 1'b1; cyc(1);
    tx_ready = 1'b0; bus_sends = 3'b111;
    for (int k = 0; k < 2 * AD; k++) begin
      bus_data = 32'h80 + k;
      cyc(1);
    end
    bus_sends = '0;
    cyc(2);
    tx_log.delete();
    tx_ready = 1'b1;
    cyc(14);
    check("t5_grant_count", tx_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t5_rr_order", (tx_log.size() > i) ? tx_log[i] : 99, exp_rr[i]);

    // Reset mid-count and mid-offer clears everything.
    tx_ready = 1'b0; bus_sends = 3'b010; bus_data = 32'h3C;
    rx_valid = 1'b1; rx_channel = 2'd1; rx_data = 8'h5A;
    cyc(1); rx_valid = 1'b0;
    cyc(5);
    check("t6_pre_tx_valid", tx_valid, 1);
    check("t6_pre_recv", bus_recv_sends[1], 1);
    reset = 1'b0;
    #1;
    check("t6_rst_acks", bus_send_acks, 0);
    check("t6_rst_recv_sends", bus_recv_sends, 0);
    check("t6_rst_recv_datas", bus_recv_datas[63:32], 0);
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_channel", tx_channel, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_rx_ready", rx_ready, 0);
    bus_sends = '0;
    cyc(2); reset = 1'b1;
    cyc(5);
    check("t6_post_tx_valid", tx_valid, 0);
    check("t6_post_recv", bus_recv_sends, 0);
    bus_sends = 3'b010;
    cyc(3); check("t6_count_restarted", bus_send_acks[1], 0);
    cyc(1); check("t6_ack_after_4", bus_send_acks[1], 1);
    bus_sends = '0; tx_ready = 1'b1;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
